sram_1r1w_param: RTL and testbench
==================================

Name: sram_1r1w_param

Overview:
- Parametrised successor of the convolution image-buffer SRAMs: one write port and one independent read port on a single clock.
- Adds byte-enable writes, selectable read latency, defined read/write collision behaviour and a hardware clear engine.
- Sits between the image loader / convolution datapath and the pixel/feature storage.
- Replaces per-instance fixed-size copies with one block.

Parameters:
- DATA_W, 8, word width in bits; must be a multiple of 8.
- ADDR_W, 15, address width.
- DEPTH, 32768, number of words; must be at most 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
- COLLIDE_MODE, 0, same-address read and write in one cycle: 0 = read-old, 1 = write-through.
- INIT_FILE, "", hex file loaded at elaboration; empty means no preload.
- CLR_VAL, 0, word written by the clear engine.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- w_en  in  1  write request
- w_addr  in  ADDR_W  write address
- w_be  in  DATA_W/8  byte enables, bit i covers byte i
- w_data  in  DATA_W  write data
- r_en  in  1  read request
- r_addr  in  ADDR_W  read address
- r_data  out  DATA_W  read data
- r_valid  out  1  r_data carries the response to a request
- clr_req  in  1  start clear, one-cycle pulse
- clr_busy  out  1  clear engine active

Behaviour:
- Reset:
  - Asynchronous, active-low; clk is the only clock.
  - r_data=0, r_valid=0, clr_busy=0, FSM=IDLE, clear counter=0, read pipeline flushed.
  - Memory contents are not reset.
- Write:
  - On a clk edge with w_en=1, FSM=IDLE and w_addr<DEPTH, each byte i with w_be[i]=1 is updated.
  - Bytes with w_be[i]=0 keep their old value.
  - A write to w_addr>=DEPTH is dropped.
- Read:
  - r_en=1 in cycle t with FSM=IDLE is accepted.
  - RD_LAT=1: r_data and r_valid are updated at edge t+1.
  - RD_LAT=2: one extra output register, so the update is at edge t+2.
  - r_valid pulses for one cycle per accepted read.
  - One read can be accepted per cycle; the read pipeline never stalls.
  - r_data holds its last value when there is no response.
  - A read with r_addr>=DEPTH returns 0 with r_valid=1.
- Collision (w_en and r_en in the same cycle, w_addr==r_addr, in range):
  - COLLIDE_MODE=0: response is the pre-write word.
  - COLLIDE_MODE=1: response is the post-write word, i.e. new bytes merged with old bytes under w_be.
- Clear FSM:
  - IDLE -> CLEAR on clr_req=1.
  - In CLEAR, CLR_VAL is written to address cnt every cycle and cnt increments.
  - When cnt==DEPTH-1 is written, the FSM returns to IDLE and cnt resets to 0.
  - Clear takes exactly DEPTH cycles; clr_busy=1 throughout CLEAR and rises the cycle after clr_req.
  - During CLEAR, external writes are dropped and reads are not accepted (no r_valid).
  - Reads accepted before CLEAR still complete their pipeline normally.
  - clr_req while clr_busy=1 is ignored.
  - If clr_req, w_en and r_en arrive in the same IDLE cycle, the write and read are performed first and the clear starts next cycle.
- Reset mid-clear:
  - The clear aborts and the FSM goes to IDLE.
  - Addresses already cleared keep CLR_VAL; the rest keep their prior contents.
- Elaboration checks: DATA_W%8!=0, RD_LAT not in {1,2}, or DEPTH>2**ADDR_W is a fatal error.

Decomposition:
- Package sram_pkg holds:
  - COLLIDE_READ_OLD=0 and COLLIDE_WRITE_THRU=1;
  - the clear FSM state enum {IDLE, CLEAR};
  - a function byte_merge(old, new, be).
- Sub-module sram_clear_fsm: counter plus state, with outputs clr_busy, clr_we and clr_addr.
- The top level muxes between the clear write and the user write, and holds the array and the read pipeline.

Test Plan:
- Read latency: preload addr 5=0xA7; r_en, r_addr=5 -> RD_LAT=1: r_data=0xA7 with r_valid=1 one cycle later; RD_LAT=2: two cycles later, and r_valid is low in the intermediate cycle.
- Byte enables: DATA_W=32, addr 3=0x11223344; write 0xAABBCCDD with w_be=4'b0101 -> read of addr 3 returns 0x11BB33DD.
- Collision: addr 7=0x10; write 0x20 and read addr 7 in the same cycle -> COLLIDE_MODE=0 returns 0x10; COLLIDE_MODE=1 returns 0x20; a later read returns 0x20.
- Clear with contention: DEPTH=16, CLR_VAL=0xFF; clr_req, then w_en to addr 2 with 0x55 during clear -> clr_busy is high for 16 cycles, r_en during clear gives no r_valid, and afterwards all 16 addresses read 0xFF.
- Reset mid-clear: DEPTH=16, all words 0x00, CLR_VAL=0xFF; assert rst_n=0 after 6 clear cycles -> r_valid=0 and clr_busy=0 immediately; addrs 0-5 read 0xFF and addrs 6-15 read 0x00.
- Out of range: DEPTH=10, ADDR_W=4; write to addr 12, then read addr 12 -> r_data=0 with r_valid=1, and addrs 0-9 are unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the 1R1W SRAM: collision-mode codes, clear FSM
// states and the byte-enable merge used by the write-through bypass.
package sram_pkg;

  localparam int COLLIDE_READ_OLD   = 0;
  localparam int COLLIDE_WRITE_THRU = 1;

  // Widest word byte_merge handles; callers size-cast in and out.
  localparam int MERGE_MAX_W = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < MERGE_MAX_W / 8; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear engine: sweeps every address once, emitting one write per cycle,
// then drops back to IDLE. Requests seen while sweeping are ignored.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) state_q <= CLEAR;
        end
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/sram_1r1w_param.sv
// One-write/one-read SRAM with byte enables, 1- or 2-cycle read latency,
// selectable same-address collision behaviour and a hardware clear engine.
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                ADDR_W       = 15,
  parameter int                DEPTH        = 32768,
  parameter int                RD_LAT       = 1,
  parameter int                COLLIDE_MODE = COLLIDE_READ_OLD,
  parameter string             INIT_FILE    = "",
  parameter logic [DATA_W-1:0] CLR_VAL      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [ADDR_W-1:0]     w_addr,
  input  logic [DATA_W/8-1:0]   w_be,
  input  logic [DATA_W-1:0]     w_data,
  input  logic                  r_en,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic [DATA_W-1:0]     r_data,
  output logic                  r_valid,
  input  logic                  clr_req,
  output logic                  clr_busy
);

  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MERGE_MAX_W) begin : g_bad_data_w
    $fatal(1, "sram_1r1w_param: DATA_W=%0d must be a non-zero multiple of 8", DATA_W);
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $fatal(1, "sram_1r1w_param: RD_LAT=%0d must be 1 or 2", RD_LAT);
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $fatal(1, "sram_1r1w_param: DEPTH=%0d does not fit ADDR_W=%0d", DEPTH, ADDR_W);
  end
  if (COLLIDE_MODE != COLLIDE_READ_OLD && COLLIDE_MODE != COLLIDE_WRITE_THRU) begin : g_bad_mode
    $fatal(1, "sram_1r1w_param: COLLIDE_MODE=%0d is not supported", COLLIDE_MODE);
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle;
  logic              w_in_range;
  logic              r_in_range;
  logic              user_we;
  logic              rd_acc;
  logic              collide;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_rd_q;
  logic              s1_valid_q;
  logic              s1_zero_q;
  logic              s1_byp_q;
  logic [DATA_W-1:0] s1_wdata_q;
  logic [NB-1:0]     s1_be_q;
  logic [DATA_W-1:0] s1_word;

  sram_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign idle       = !clr_busy;
  assign w_in_range = ({1'b0, w_addr} < DEPTH_L);
  assign r_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign user_we    = w_en && idle && w_in_range;
  assign rd_acc     = r_en && idle;
  assign collide    = user_we && rd_acc && (w_addr == r_addr);

  // The clear engine only runs while user writes are blocked, so the mux never contends.
  assign mem_we    = user_we || clr_we;
  assign mem_widx  = clr_we ? clr_addr[IDX_W-1:0] : w_addr[IDX_W-1:0];
  assign mem_wdata = clr_we ? CLR_VAL : w_data;
  assign mem_be    = clr_we ? {NB{1'b1}} : w_be;

  // Read-first array: mem_rd_q sees the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem_q[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (rd_acc && r_in_range) mem_rd_q <= mem_q[r_addr[IDX_W-1:0]];
  end

  // Side-band flags steer the raw array output; s1_zero_q resetting high gives r_data=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b1;
      s1_byp_q   <= 1'b0;
      s1_wdata_q <= '0;
      s1_be_q    <= '0;
    end else begin
      s1_valid_q <= rd_acc;
      if (rd_acc) begin
        s1_zero_q  <= !r_in_range;
        s1_byp_q   <= (COLLIDE_MODE == COLLIDE_WRITE_THRU) && collide;
        s1_wdata_q <= w_data;
        s1_be_q    <= w_be;
      end
    end
  end

  always_comb begin
    s1_word = mem_rd_q;
    if (s1_zero_q) begin
      s1_word = '0;
    end else if (s1_byp_q) begin
      s1_word = DATA_W'(byte_merge(MERGE_MAX_W'(mem_rd_q), MERGE_MAX_W'(s1_wdata_q),
                                   (MERGE_MAX_W / 8)'(s1_be_q)));
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign r_data  = s1_word;
    assign r_valid = s1_valid_q;
  end else begin : g_lat2
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_data_q <= s1_word;
      end
    end

    assign r_data  = out_data_q;
    assign r_valid = out_valid_q;
  end

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Bench for sram_1r1w_param: instance A (8-bit, 16 deep, 1-cycle, read-old, clear to FF)
// and instance B (32-bit, 10 deep, 2-cycle, write-through) against a response scoreboard.
module tb_sram_1r1w_param;

  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic          a_rst_n, a_w_en, a_r_en, a_clr_req, a_r_valid, a_clr_busy;
  logic [AW-1:0] a_w_addr, a_r_addr;
  logic [0:0]    a_w_be;
  logic [7:0]    a_w_data, a_r_data;

  logic          b_rst_n, b_w_en, b_r_en, b_clr_req, b_r_valid, b_clr_busy;
  logic [AW-1:0] b_w_addr, b_r_addr;
  logic [3:0]    b_w_be;
  logic [31:0]   b_w_data, b_r_data;

  sram_1r1w_param #(
    .DATA_W(8), .ADDR_W(AW), .DEPTH(16), .RD_LAT(1), .COLLIDE_MODE(0),
    .INIT_FILE(""), .CLR_VAL(8'hFF)
  ) u_a (
    .clk(clk), .rst_n(a_rst_n), .w_en(a_w_en), .w_addr(a_w_addr), .w_be(a_w_be),
    .w_data(a_w_data), .r_en(a_r_en), .r_addr(a_r_addr), .r_data(a_r_data),
    .r_valid(a_r_valid), .clr_req(a_clr_req), .clr_busy(a_clr_busy)
  );

  sram_1r1w_param #(
    .DATA_W(32), .ADDR_W(AW), .DEPTH(10), .RD_LAT(2), .COLLIDE_MODE(1),
    .INIT_FILE(""), .CLR_VAL(32'h0)
  ) u_b (
    .clk(clk), .rst_n(b_rst_n), .w_en(b_w_en), .w_addr(b_w_addr), .w_be(b_w_be),
    .w_data(b_w_data), .r_en(b_r_en), .r_addr(b_r_addr), .r_data(b_r_data),
    .r_valid(b_r_valid), .clr_req(b_clr_req), .clr_busy(b_clr_busy)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  typedef struct {
    bit          sel_b;
    bit          we;
    logic [3:0]  waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          re;
    logic [3:0]  raddr;
    logic [31:0] rexp;
    string       name;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Response monitors: every r_valid pops one expectation; data and arrival cycle are checked.
  always @(negedge clk) begin
    exp_t e;
    if (a_rst_n && a_r_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rvalid", 32'(a_r_valid), 32'd0);
      end else begin
        e = qa.pop_front();
        chk(e.name, 32'(a_r_data), e.data);
        chk({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
        $display("A read %s: data=0x%02h cycle=%0d", e.name, a_r_data, cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rst_n && b_r_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rvalid", 32'(b_r_valid), 32'd0);
      end else begin
        e = qb.pop_front();
        chk(e.name, b_r_data, e.data);
        chk({e.name, "_lat"}, 32'(cyc), 32'(e.cyc));
        $display("B read %s: data=0x%08h cycle=%0d", e.name, b_r_data, cyc);
      end
    end
  end

  task automatic idle_inputs();
    a_w_en = 1'b0; a_r_en = 1'b0; a_clr_req = 1'b0;
    b_w_en = 1'b0; b_r_en = 1'b0; b_clr_req = 1'b0;
  endtask

  task automatic wr_a(input logic [3:0] addr, input logic [7:0] data);
    a_w_en = 1'b1; a_w_addr = addr; a_w_be = 1'b1; a_w_data = data;
    tick();
    a_w_en = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [31:0] data);
    b_w_en = 1'b1; b_w_addr = addr; b_w_be = 4'hF; b_w_data = data;
    tick();
    b_w_en = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] addr, input logic [31:0] req, input string n);
    a_r_en = 1'b1; a_r_addr = addr;
    qa.push_back('{data: req, cyc: cyc + 1, name: n});
    tick();
    a_r_en = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] addr, input logic [31:0] req, input string n);
    b_r_en = 1'b1; b_r_addr = addr;
    qb.push_back('{data: req, cyc: cyc + 2, name: n});
    tick();
    b_r_en = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    if (!v.sel_b) begin
      a_w_en = v.we; a_w_addr = v.waddr; a_w_be = v.be[0:0]; a_w_data = v.wdata[7:0];
      a_r_en = v.re; a_r_addr = v.raddr;
      if (v.re) qa.push_back('{data: v.rexp, cyc: cyc + 1, name: v.name});
    end else begin
      b_w_en = v.we; b_w_addr = v.waddr; b_w_be = v.be; b_w_data = v.wdata;
      b_r_en = v.re; b_r_addr = v.raddr;
      if (v.re) qb.push_back('{data: v.rexp, cyc: cyc + 2, name: v.name});
    end
    tick();
    idle_inputs();
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 10 && (qa.size() + qb.size()) != 0; i++) tick();
    chk({n, "_a_pending"}, 32'(qa.size()), 32'd0);
    chk({n, "_b_pending"}, 32'(qb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_b [10];
    int          busy_cnt;

    //            sel   we    waddr  be     wdata          re    raddr  rexp           name
    vt[0]  = '{1'b0, 1'b1, 4'd5,  4'h1, 32'h0000_00A7, 1'b0, 4'd0,  32'h0,         "a_wr5"};
    vt[1]  = '{1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 4'd5,  32'h0000_00A7, "a_lat1_addr5"};
    vt[2]  = '{1'b0, 1'b1, 4'd7,  4'h1, 32'h0000_0010, 1'b0, 4'd0,  32'h0,         "a_wr7"};
    vt[3]  = '{1'b0, 1'b1, 4'd7,  4'h1, 32'h0000_0020, 1'b1, 4'd7,  32'h0000_0010, "a_collide_old"};
    vt[4]  = '{1'b0, 1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 4'd7,  32'h0000_0020, "a_after_collide"};
    vt[5]  = '{1'b1, 1'b1, 4'd5,  4'hF, 32'h0000_00A7, 1'b0, 4'd0,  32'h0,         "b_wr5"};
    vt[6]  = '{1'b1, 1'b1, 4'd3,  4'hF, 32'h1122_3344, 1'b0, 4'd0,  32'h0,         "b_wr3"};
    vt[7]  = '{1'b1, 1'b1, 4'd7,  4'hF, 32'h0000_0010, 1'b0, 4'd0,  32'h0,         "b_wr7"};
    vt[8]  = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 4'd5,  32'h0000_00A7, "b_lat2_addr5"};
    vt[9]  = '{1'b1, 1'b1, 4'd3,  4'h5, 32'hAABB_CCDD, 1'b0, 4'd0,  32'h0,         "b_wr3_be"};
    vt[10] = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 4'd3,  32'h11BB_33DD, "b_byte_en"};
    vt[11] = '{1'b1, 1'b1, 4'd7,  4'hF, 32'h0000_0020, 1'b1, 4'd7,  32'h0000_0020, "b_collide_thru"};
    vt[12] = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 4'd7,  32'h0000_0020, "b_after_collide"};
    vt[13] = '{1'b1, 1'b1, 4'd12, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'd0,  32'h0,         "b_wr_oob"};
    vt[14] = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 4'd12, 32'h0,         "b_oob_read"};
    vt[15] = '{1'b1, 1'b1, 4'd2,  4'h8, 32'h5566_7788, 1'b1, 4'd2,  32'h55DE_0002, "b_collide_merge"};
    vt[16] = '{1'b1, 1'b0, 4'd0,  4'h0, 32'h0,         1'b1, 4'd2,  32'h55DE_0002, "b_after_merge"};

    for (int k = 0; k < 10; k++) exp_b[k] = 32'hC0DE_0000 + 32'(k);
    exp_b[2] = 32'h55DE_0002;
    exp_b[3] = 32'h11BB_33DD;
    exp_b[5] = 32'h0000_00A7;
    exp_b[7] = 32'h0000_0020;

    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_w_addr = '0; a_r_addr = '0; a_w_be = '0; a_w_data = '0;
    b_w_addr = '0; b_r_addr = '0; b_w_be = '0; b_w_data = '0;
    idle_inputs();
    tick(); tick();
    chk("a_rst_rdata",  32'(a_r_data),   32'd0);
    chk("a_rst_rvalid", 32'(a_r_valid),  32'd0);
    chk("a_rst_busy",   32'(a_clr_busy), 32'd0);
    chk("b_rst_rdata",  b_r_data,        32'd0);
    chk("b_rst_rvalid", 32'(b_r_valid),  32'd0);
    chk("b_rst_busy",   32'(b_clr_busy), 32'd0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) wr_b(4'(k), 32'hC0DE_0000 + 32'(k));

    for (int i = 0; i < 17; i++) apply(vt[i]);
    drain("table");

    chk("b_rdata_hold",  b_r_data,       32'h55DE_0002);
    chk("b_rvalid_idle", 32'(b_r_valid), 32'd0);

    for (int k = 0; k < 10; k++) rd_b(4'(k), exp_b[k], $sformatf("b_readback%0d", k));
    drain("b_readback");

    // Clear with a read, a repeated request and a write landing mid-sweep.
    for (int k = 0; k < 16; k++) wr_a(4'(k), 8'h30 + 8'(k));
    a_clr_req = 1'b1;
    tick();
    a_clr_req = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 40 && a_clr_busy; n++) begin
      busy_cnt++;
      if (n == 4) chk("a_clr_read_dropped", 32'(a_r_valid), 32'd0);
      idle_inputs();
      case (n)
        3:  begin a_r_en = 1'b1; a_r_addr = 4'd4; end
        5:  a_clr_req = 1'b1;
        12: begin a_w_en = 1'b1; a_w_addr = 4'd2; a_w_be = 1'b1; a_w_data = 8'h55; end
        default: ;
      endcase
      tick();
    end
    idle_inputs();
    $display("A clear: busy for %0d cycles", busy_cnt);
    chk("a_clr_busy_cycles", 32'(busy_cnt), 32'd16);
    for (int k = 0; k < 16; k++) rd_a(4'(k), 32'h0000_00FF, $sformatf("a_cleared%0d", k));
    drain("a_clear");

    // Reset mid-clear; the last zero write, a read and clr_req share one cycle.
    for (int k = 0; k < 15; k++) wr_a(4'(k), 8'h00);
    a_clr_req = 1'b1; a_w_en = 1'b1; a_w_addr = 4'd15; a_w_be = 1'b1; a_w_data = 8'h00;
    a_r_en = 1'b1; a_r_addr = 4'd15;
    qa.push_back('{data: 32'h0000_00FF, cyc: cyc + 1, name: "a_clr_same_cycle_read"});
    tick();
    idle_inputs();
    for (int n = 0; n < 6; n++) tick();
    chk("a_busy_before_reset", 32'(a_clr_busy), 32'd1);
    a_rst_n = 1'b0;
    #1;
    chk("a_midclr_rst_rvalid", 32'(a_r_valid),  32'd0);
    chk("a_midclr_rst_busy",   32'(a_clr_busy), 32'd0);
    chk("a_midclr_rst_rdata",  32'(a_r_data),   32'd0);
    $display("A reset mid-clear: r_valid=%0b clr_busy=%0b r_data=0x%02h", a_r_valid, a_clr_busy, a_r_data);
    tick();
    a_rst_n = 1'b1;
    tick();
    for (int k = 0; k < 16; k++)
      rd_a(4'(k), (k < 6) ? 32'h0000_00FF : 32'h0, $sformatf("a_partial%0d", k));
    drain("a_partial");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
